// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if
//   Bundles the fetch port, data port and shared SRAM port of the SRAM
//   arbiter into one interface.
//   Signals:
//     if_req/if_addr       fetch read request, held until if_gnt
//     if_gnt               fetch request accepted this cycle
//     if_rvalid/if_rdata   fetch read response, one cycle after grant
//     mem_req/mem_wen/mem_addr/mem_wdata  data request, held until mem_gnt
//     mem_gnt              data request accepted this cycle
//     mem_rvalid/mem_rdata data read response (reads only)
//     sram_en/sram_wen/sram_addr/sram_wdata  shared single-port SRAM command
//     sram_rdata           SRAM read data, one cycle after an enabled read
//   Modports:
//     slave   the arbiter side
//     master  the requestor/SRAM side (pipeline and memory model)
interface sram_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        mem_req;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport slave (
    input  if_req, if_addr, mem_req, mem_wen, mem_addr, mem_wdata, sram_rdata,
    output if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata,
           sram_en, sram_wen, sram_addr, sram_wdata
  );

  modport master (
    output if_req, if_addr, mem_req, mem_wen, mem_addr, mem_wdata, sram_rdata,
    input  if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata,
           sram_en, sram_wen, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one single-port SRAM between the instruction-fetch port and the
//   data port. Data accesses win by default; grants are combinational and the
//   read response comes back one cycle later, tagged by a response-owner FSM.
//   Ports:
//     clk           sole clock, all state on the rising edge
//     reset         synchronous, active-high reset
//     cancel        pipeline flush: blocks an IF grant and kills a pending
//                   IF response in the same cycle
//     bus           sram_arbiter_if.slave (fetch, data and SRAM signals)
//     conflict_cnt  wrapping count of cycles with both requests high
//   Parameters:
//     STARVE_LIMIT  consecutive denied fetch cycles that force one fetch grant
//   Build option:
//     ARB_STARVE_GUARD_EN  when defined, adds a 3-bit starvation counter that
//                          inverts priority for one cycle at STARVE_LIMIT;
//                          when undefined, data always wins.
module sram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cancel,
  sram_arbiter_if.slave bus,
  output logic [31:0]   conflict_cnt
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_MEM_RD
  } owner_e;

  owner_e owner_q;
  owner_e owner_d;
  logic   if_gnt;
  logic   mem_gnt;
  logic   starve_hit;

  // A limit above 7 can never match the 3-bit counter, so the guard would
  // simply never fire.
  if (STARVE_LIMIT > 7) begin : g_limit_unreachable
  end

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] starve_cnt;

  assign starve_hit = (32'(starve_cnt) == STARVE_LIMIT);

  // Counts cycles a fetch waits behind data; saturates at 7 and clears on a
  // fetch grant or a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (if_gnt || cancel) begin
      starve_cnt <= '0;
    end else if (bus.if_req && (starve_cnt != 3'd7)) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  // Grant selection and response-owner next state. Reset blocks every grant.
  always_comb begin
    if_gnt  = 1'b0;
    mem_gnt = 1'b0;
    owner_d = OWN_NONE;
    if (!reset) begin
      if (starve_hit) begin
        if_gnt  = bus.if_req & ~cancel;
        mem_gnt = bus.mem_req & ~if_gnt;
      end else begin
        mem_gnt = bus.mem_req;
        if_gnt  = bus.if_req & ~bus.mem_req & ~cancel;
      end
      if (if_gnt) begin
        owner_d = OWN_IF;
      end else if (mem_gnt && (bus.mem_wen == 4'b0000)) begin
        owner_d = OWN_MEM_RD;
      end
    end
  end

  // Response owner: who gets next cycle's sram_rdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Contention statistics, wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_cnt <= '0;
    end else if (bus.if_req && bus.mem_req) begin
      conflict_cnt <= conflict_cnt + 32'd1;
    end
  end

  assign bus.if_gnt     = if_gnt;
  assign bus.mem_gnt    = mem_gnt;
  assign bus.sram_en    = if_gnt | mem_gnt;
  assign bus.sram_wen   = mem_gnt ? bus.mem_wen : 4'b0000;
  assign bus.sram_addr  = if_gnt ? bus.if_addr : bus.mem_addr;
  assign bus.sram_wdata = if_gnt ? 32'd0 : bus.mem_wdata;

  assign bus.if_rvalid  = (owner_q == OWN_IF) & ~cancel & ~reset;
  assign bus.mem_rvalid = (owner_q == OWN_MEM_RD) & ~reset;
  assign bus.if_rdata   = bus.sram_rdata;
  assign bus.mem_rdata  = bus.sram_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Self-checking bench for sram_arbiter. A small reference model predicts
//   grants, SRAM commands and rvalids each cycle; expected read data is
//   pushed to per-port queues at grant time and popped in the response cycle.
//   A behavioural SRAM answers the DUT's SRAM port.
//   Honours ARB_STARVE_GUARD_EN the same way as the design.
module tb_sram_arbiter;

  localparam int StarveLimit = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cancel;
  logic [31:0] conflict_cnt;

  sram_arbiter_if bus ();

  sram_arbiter #(.STARVE_LIMIT(StarveLimit)) dut (
    .clk          (clk),
    .reset        (reset),
    .cancel       (cancel),
    .bus          (bus.slave),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] initWord(input int i);
    return (i == 0) ? 32'h3C010001 : (32'hC0DE0000 | 32'(i * 17));
  endfunction

  // Behavioural single-port SRAM: byte writes in the grant cycle, read data
  // registered for the next cycle; contents reload on reset.
  logic [31:0] sramArray [16];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) sramArray[i] <= initWord(i);
    end else if (bus.sram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.sram_wen[b])
          sramArray[bus.sram_addr[5:2]][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
      bus.sram_rdata <= sramArray[bus.sram_addr[5:2]];
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] shadow [16];
  logic [31:0] ifQ [$];
  logic [31:0] memQ [$];
  int          mOwner;
  logic [31:0] mConf;
  int          mCnt;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) shadow[i] = initWord(i);
    ifQ.delete();
    memQ.delete();
    mOwner = 0;
    mConf  = 32'd0;
    mCnt   = 0;
  endtask

  // Drives one cycle of inputs, checks the DUT against the model, then
  // advances the model across the clock edge.
  task automatic applyStimulus(input logic r, input logic c,
                               input logic ir, input logic [31:0] ia,
                               input logic mr, input logic [3:0] mw,
                               input logic [31:0] ma, input logic [31:0] md);
    logic        eIf, eMem, hit, expValid;
    logic [31:0] d;
    reset         = r;
    cancel        = c;
    bus.if_req    = ir;
    bus.if_addr   = ia;
    bus.mem_req   = mr;
    bus.mem_wen   = mw;
    bus.mem_addr  = ma;
    bus.mem_wdata = md;
    #3;
`ifdef ARB_STARVE_GUARD_EN
    hit = (mCnt == StarveLimit);
`else
    hit = 1'b0;
`endif
    if (r) begin
      eIf = 1'b0; eMem = 1'b0;
    end else if (hit) begin
      eIf = ir & ~c; eMem = mr & ~eIf;
    end else begin
      eMem = mr; eIf = ir & ~mr & ~c;
    end
    checkOutput("if_gnt", 32'(bus.if_gnt), 32'(eIf));
    checkOutput("mem_gnt", 32'(bus.mem_gnt), 32'(eMem));
    checkOutput("sram_en", 32'(bus.sram_en), 32'(eIf | eMem));
    checkOutput("sram_wen", 32'(bus.sram_wen), 32'(eMem ? mw : 4'h0));
    if (eIf | eMem) begin
      checkOutput("sram_addr", bus.sram_addr, eIf ? ia : ma);
      checkOutput("sram_wdata", bus.sram_wdata, eIf ? 32'd0 : md);
    end
    checkOutput("conflict_cnt", conflict_cnt, mConf);

    if (mOwner == 1 && ifQ.size() > 0) begin
      d = ifQ.pop_front();
      expValid = ~c & ~r;
      checkOutput("if_rvalid", 32'(bus.if_rvalid), 32'(expValid));
      if (expValid) checkOutput("if_rdata", bus.if_rdata, d);
    end else begin
      checkOutput("if_rvalid", 32'(bus.if_rvalid), 32'd0);
    end
    if (mOwner == 2 && memQ.size() > 0) begin
      d = memQ.pop_front();
      expValid = ~r;
      checkOutput("mem_rvalid", 32'(bus.mem_rvalid), 32'(expValid));
      if (expValid) checkOutput("mem_rdata", bus.mem_rdata, d);
    end else begin
      checkOutput("mem_rvalid", 32'(bus.mem_rvalid), 32'd0);
    end

    if (eIf) ifQ.push_back(shadow[ia[5:2]]);
    if (eMem && mw == 4'h0) memQ.push_back(shadow[ma[5:2]]);
    if (eMem)
      for (int b = 0; b < 4; b++)
        if (mw[b]) shadow[ma[5:2]][8*b +: 8] = md[8*b +: 8];
    if (r) begin
      modelReset();
    end else begin
      mOwner = eIf ? 1 : ((eMem && mw == 4'h0) ? 2 : 0);
      if (ir && mr) mConf = mConf + 32'd1;
      if (eIf || c) mCnt = 0;
      else if (ir && mCnt < 7) mCnt = mCnt + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 4'h0, 32'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ra, ma, md;
    logic [3:0]  mw;
    reset = 1'b1; cancel = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_req = 1'b0; bus.mem_wen = '0; bus.mem_addr = '0; bus.mem_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();

    // Reset state with requests active: nothing may be granted
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h4, 1'b1, 4'h0, 32'h8, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h4, 1'b1, 4'hF, 32'h8, 32'h1);

    // Boot fetch then its response
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hBFC00000, 1'b0, 4'h0, 32'd0, 32'd0);
    idle();

    // Conflict: mem write wins, fetch waits then goes
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hBFC00004, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hBFC00004, 1'b0, 4'h0, 32'd0, 32'd0);
    idle();

    // Read back, partial write, read back again (back-to-back)
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 4'h0, 32'h10, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 4'b0011, 32'h10, 32'h12345678);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 4'h0, 32'h10, 32'd0);
    idle();

    // Fetch granted, flushed in its response cycle
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h8, 1'b0, 4'h0, 32'd0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hC, 1'b0, 4'h0, 32'd0, 32'd0);
    idle();

    // Flush does not touch data grants or responses
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 4'h0, 32'h10, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 4'h0, 32'd0, 32'd0);

    // Starvation scenario: both requests held six cycles
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 4'h0, 32'd0, 32'd0);
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h4, 1'b1, 4'h0, 32'h20 + 32'(i * 4), 32'd0);
    idle();

    // Reset right after a mem read grant discards the response
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 4'h0, 32'h10, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h4, 1'b1, 4'h0, 32'h10, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h4, 1'b1, 4'h0, 32'h10, 32'd0);
    idle();

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      ra = 32'hBFC00000 | (32'($urandom_range(0, 15)) << 2);
      ma = 32'($urandom_range(0, 15)) << 2;
      md = $urandom;
      mw = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), mw, ma, md);
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive denied IF-request cycles that force an IF grant when the guard feature is compiled in.
REQ-002 The block SHALL have these ports:
  clk  in  1  sole clock; all state on rising edge
  reset  in  1  synchronous, active-high reset
  cancel  in  1  pipeline flush from WB; kills pending IF response
  if_req  in  1  fetch read request, held with if_addr until if_gnt
  if_addr  in  32  fetch word address
  if_gnt  out  1  fetch request accepted this cycle
  if_rvalid  out  1  fetch read data valid
  if_rdata  out  32  fetch read data
  mem_req  in  1  data request, held with mem_addr, mem_wen and mem_wdata until mem_gnt
  mem_wen  in  4  byte write enables; 0 = read
  mem_addr  in  32  data address
  mem_wdata  in  32  data write data
  mem_gnt  out  1  data request accepted this cycle
  mem_rvalid  out  1  data read data valid (reads only)
  mem_rdata  out  32  data read data
  sram_en  out  1  shared single-port SRAM enable
  sram_wen  out  4  SRAM byte write enables
  sram_addr  out  32  SRAM address
  sram_wdata  out  32  SRAM write data
  sram_rdata  in  32  SRAM read data, valid one cycle after the enabled read
  conflict_cnt  out  32  count of cycles with if_req and mem_req both high

Function
REQ-003 At most one of if_gnt and mem_gnt SHALL be high in any cycle.
REQ-004 Default priority SHALL be mem over if: mem_gnt = mem_req; if_gnt = if_req & ~mem_req & ~cancel.
REQ-005 In a grant cycle, sram_en SHALL be 1 and sram_addr, sram_wen and sram_wdata SHALL be driven combinationally from the winner; an IF grant SHALL drive sram_wen = 0 and sram_wdata = 0.
REQ-006 With no grant, sram_en SHALL be 0 and sram_wen SHALL be 0.
REQ-007 A response-owner register SHALL hold one of three states: NONE, IF, MEM_RD. Next state: IF after an IF grant, MEM_RD after a mem grant with mem_wen = 0, otherwise NONE.
REQ-008 if_rvalid SHALL equal (owner == IF) & ~cancel, and mem_rvalid SHALL equal (owner == MEM_RD); each gives 1-cycle latency from grant.
REQ-009 if_rdata and mem_rdata SHALL both pass sram_rdata through combinationally.
REQ-010 Back-to-back grants SHALL be allowed every cycle; throughput is one access per cycle.
REQ-011 A mem write SHALL produce no rvalid; the write commits in the grant cycle.
REQ-012 cancel SHALL suppress an IF grant in the same cycle and suppress if_rvalid for an IF response pending in that cycle; mem grants and responses are unaffected.
REQ-013 conflict_cnt SHALL increment by 1 in each cycle with if_req & mem_req and wrap from 0xFFFFFFFF to 0.

Reset
REQ-014 While reset = 1 at a clock edge, the owner register SHALL go to NONE, conflict_cnt to 0, and the starvation counter to 0.
REQ-015 While reset = 1, if_gnt, mem_gnt, sram_en, if_rvalid and mem_rvalid SHALL be 0, and sram_wen SHALL be 0.
REQ-016 Reset SHALL take priority over cancel and all requests; a response pending when reset asserts SHALL be discarded.
REQ-017 After reset deasserts, if_rdata, mem_rdata, sram_addr and sram_wdata SHALL follow REQ-005 and REQ-009.

Configuration
REQ-018 Macro ARB_STARVE_GUARD_EN SHALL control the starvation guard.
REQ-019 With ARB_STARVE_GUARD_EN defined, a 3-bit saturating counter SHALL increment on each cycle with if_req & ~if_gnt & ~cancel, and clear on if_gnt or cancel.
REQ-020 With ARB_STARVE_GUARD_EN defined and counter == STARVE_LIMIT, priority SHALL invert for one cycle: if_gnt = if_req & ~cancel and mem_gnt = mem_req & ~if_gnt.
REQ-021 With ARB_STARVE_GUARD_EN undefined, the counter SHALL not exist and strict REQ-004 priority SHALL apply.

Verification
REQ-022 Scenario: if_req = 1, if_addr = 0xBFC00000, mem_req = 0, sram_rdata = 0x3C010001 next cycle -> if_gnt = 1, sram_addr = 0xBFC00000, then if_rvalid = 1 with if_rdata = 0x3C010001.
REQ-023 Scenario: both requests high, mem_wen = 0xF, mem_addr = 0x10, mem_wdata = 0xDEADBEEF -> mem_gnt = 1, if_gnt = 0, sram_wen = 0xF, no mem_rvalid next cycle, conflict_cnt = 1.
REQ-024 Scenario: IF granted, then cancel = 1 in the response cycle -> if_rvalid = 0 that cycle, if_gnt = 0 that cycle, owner returns to NONE.
REQ-025 Scenario: guard defined, mem_req and if_req held high for 6 cycles -> mem_gnt in cycles 0-3, if_gnt in cycle 4, mem_gnt in cycle 5; guard undefined -> mem_gnt in all 6 cycles.
REQ-026 Scenario: reset asserted in the cycle after a mem read grant -> mem_rvalid = 0, conflict_cnt = 0, sram_en = 0 while reset = 1.
